// File: rtl/gen_counter_if.sv
// gen_counter_if -- control and status bundle for gen_counter.
//
// Signals:
//   sclr_n    synchronous clear, active-low
//   load_n    synchronous parallel load, active-low
//   p         load data
//   ent, enp  count enables (both high for a count step)
//   up        direction: 1 = up, 0 = down
//   mode      00 free-run, 01 modulo, 10 one-shot, 11 free-run
//   lim       limit for modulo / one-shot modes
//   q         registered count
//   rco       ripple carry out (combinational)
//   tc_pulse  registered one-cycle terminal-count event
//   done      registered one-shot completion flag
//
// master: the side that controls the counter; slave: the counter itself.
interface gen_counter_if #(
    parameter int WIDTH = 8
);
    logic             sclr_n;
    logic             load_n;
    logic [WIDTH-1:0] p;
    logic             ent;
    logic             enp;
    logic             up;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] q;
    logic             rco;
    logic             tc_pulse;
    logic             done;

    modport master (
        output sclr_n, load_n, p, ent, enp, up, mode, lim,
        input  q, rco, tc_pulse, done
    );

    modport slave (
        input  sclr_n, load_n, p, ent, enp, up, mode, lim,
        output q, rco, tc_pulse, done
    );
endinterface

// File: rtl/gen_counter.sv
// gen_counter -- programmable up/down counter, binary or BCD, with
// free-run, modulo and one-shot modes.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears q, tc_pulse, done)
//   bus    gen_counter_if.slave: controls in, q/rco/tc_pulse/done out
//
// Parameters:
//   WIDTH  counter width, 4..32 (multiple of 4 when BCD = 1)
//   BCD    0 = binary count, 1 = every nibble is a decade digit
module gen_counter #(
    parameter int WIDTH = 8,
    parameter bit BCD   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    gen_counter_if.slave bus
);

    localparam int         NIB       = WIDTH / 4;
    localparam logic [1:0] MODE_MOD  = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;

    // Largest representable count: all ones, or all nibbles 9 in BCD.
    function automatic logic [WIDTH-1:0] full_scale();
        logic [WIDTH-1:0] r;
        r = '1;
        if (BCD) begin
            r = '0;
            for (int i = 0; i < NIB; i++) r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] MAX_VAL = full_scale();

    // Increment. In BCD a nibble of 9 or above (illegal codes included)
    // rolls to 0 and carries into the next nibble.
    function automatic logic [WIDTH-1:0] inc_val(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             carry;
        if (!BCD) return v + 1'b1;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decrement. In BCD a 0 nibble becomes 9 and borrows; any other nibble
    // (illegal codes included) simply decrements in binary, no borrow.
    function automatic logic [WIDTH-1:0] dec_val(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             borrow;
        if (!BCD) return v - 1'b1;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             done_r;

    logic             limited;
    logic             one_shot;
    logic [WIDTH-1:0] tv;
    logic             at_tv;
    logic             step;
    logic [WIDTH-1:0] wrap_val;

    assign limited  = (bus.mode == MODE_MOD) || (bus.mode == MODE_ONE);
    assign one_shot = (bus.mode == MODE_ONE);

    // Terminal value for the current direction and mode.
    assign tv       = !bus.up ? '0 : (limited ? bus.lim : MAX_VAL);
    assign at_tv    = (q_r == tv);
    assign step     = bus.ent & bus.enp;

    // Value taken when stepping at the terminal value (not used in one-shot).
    assign wrap_val = bus.up ? '0 : (limited ? bus.lim : MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (!bus.sclr_n) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (!bus.load_n) begin
            q_r    <= bus.p;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (step && !done_r) begin
            if (at_tv) begin
                tc_r <= 1'b1;
                // One-shot freezes q at the terminal value and latches done.
                if (one_shot) done_r <= 1'b1;
                else          q_r    <= wrap_val;
            end else begin
                // Off-terminal steps count naturally, including the case of
                // q above lim in modulo mode, which passes through the
                // free-run wrap without raising tc_pulse.
                q_r  <= bus.up ? inc_val(q_r) : dec_val(q_r);
                tc_r <= 1'b0;
            end
        end else begin
            tc_r <= 1'b0;
        end
    end

    assign bus.q        = q_r;
    assign bus.tc_pulse = tc_r;
    assign bus.done     = done_r;
    assign bus.rco      = bus.ent & at_tv;

endmodule

// File: tb/tb_gen_counter.sv
// tb_gen_counter -- self-checking bench for gen_counter.
// A binary WIDTH=8 instance is checked against an arithmetic reference model
// under directed and random stimulus; a BCD WIDTH=8 instance is checked
// against hand-derived decimal vectors.
module tb_gen_counter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gen_counter_if #(.WIDTH(8)) bi ();
    gen_counter_if #(.WIDTH(8)) ci ();

    gen_counter #(.WIDTH(8), .BCD(1'b0)) dut_bin (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bi)
    );

    gen_counter #(.WIDTH(8), .BCD(1'b1)) dut_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ci)
    );

    int checks = 0;
    int errors = 0;

    // Reference state for the binary instance, as plain integers.
    int m_q    = 0;
    int m_done = 0;
    int m_tc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int tv_of(input int up, input int mode, input int lim);
        if (up == 0) return 0;
        if (mode == 1 || mode == 2) return lim;
        return 255;
    endfunction

    // One clock of the binary instance: drive, check rco, clock, check state.
    task automatic bin_step(input bit sclr_n, input bit load_n, input int p,
                            input bit ent, input bit enp, input bit up,
                            input int mode, input int lim);
        int tv, nq, nd, nt;
        bi.sclr_n = sclr_n;
        bi.load_n = load_n;
        bi.p      = p[7:0];
        bi.ent    = ent;
        bi.enp    = enp;
        bi.up     = up;
        bi.mode   = mode[1:0];
        bi.lim    = lim[7:0];
        #1;
        tv = tv_of(up, mode, lim);
        chk("bin_rco", {31'd0, bi.rco}, (ent && m_q == tv) ? 1 : 0);

        nq = m_q;
        nd = m_done;
        nt = 0;
        if (!sclr_n) begin
            nq = 0;
            nd = 0;
        end else if (!load_n) begin
            nq = p;
            nd = 0;
        end else if (ent && enp && m_done == 0) begin
            if (m_q == tv) begin
                nt = 1;
                if (mode == 2)      nd = 1;
                else if (up)        nq = 0;
                else if (mode == 1) nq = lim;
                else                nq = 255;
            end else begin
                nq = up ? (m_q + 1) % 256 : (m_q + 255) % 256;
            end
        end

        @(posedge clk);
        #1;
        m_q    = nq;
        m_done = nd;
        m_tc   = nt;
        chk("bin_q",    {24'd0, bi.q},         m_q);
        chk("bin_tc",   {31'd0, bi.tc_pulse},  m_tc);
        chk("bin_done", {31'd0, bi.done},      m_done);
    endtask

    // One clock of the BCD instance against explicit expectations.
    task automatic bcd_step(input bit load_n, input logic [7:0] p, input bit ent,
                            input bit up, input logic [1:0] mode, input logic [7:0] lim,
                            input bit exp_rco, input logic [7:0] exp_q, input bit exp_tc);
        ci.sclr_n = 1'b1;
        ci.load_n = load_n;
        ci.p      = p;
        ci.ent    = ent;
        ci.enp    = ent;
        ci.up     = up;
        ci.mode   = mode;
        ci.lim    = lim;
        #1;
        chk("bcd_rco", {31'd0, ci.rco}, {31'd0, exp_rco});
        @(posedge clk);
        #1;
        chk("bcd_q",  {24'd0, ci.q},        {24'd0, exp_q});
        chk("bcd_tc", {31'd0, ci.tc_pulse}, {31'd0, exp_tc});
    endtask

    initial begin
        rst_n = 1'b0;
        bi.sclr_n = 1'b1; bi.load_n = 1'b1; bi.p = '0; bi.ent = 1'b0; bi.enp = 1'b0;
        bi.up = 1'b1; bi.mode = 2'b00; bi.lim = '0;
        ci.sclr_n = 1'b1; ci.load_n = 1'b1; ci.p = '0; ci.ent = 1'b0; ci.enp = 1'b0;
        ci.up = 1'b1; ci.mode = 2'b00; ci.lim = '0;
        #12;
        chk("rst_q",    {24'd0, bi.q},        0);
        chk("rst_tc",   {31'd0, bi.tc_pulse}, 0);
        chk("rst_done", {31'd0, bi.done},     0);
        chk("rst_bcd_q", {24'd0, ci.q},       0);
        rst_n = 1'b1;

        // Free-run binary wrap with rco at 0xFF.
        bin_step(1, 0, 8'hFE, 0, 0, 1, 0, 0);
        chk("fr_load", {24'd0, bi.q}, 32'hFE);
        bin_step(1, 1, 0, 1, 1, 1, 0, 0);
        chk("fr_ff", {24'd0, bi.q}, 32'hFF);
        bi.ent = 1'b1; #1;
        chk("fr_rco_ff", {31'd0, bi.rco}, 1);
        bin_step(1, 1, 0, 1, 1, 1, 0, 0);
        chk("fr_wrap", {24'd0, bi.q}, 0);
        chk("fr_tc", {31'd0, bi.tc_pulse}, 1);
        bin_step(1, 1, 0, 1, 0, 1, 0, 0);
        chk("fr_tc_one", {31'd0, bi.tc_pulse}, 0);

        // Modulo 5 up, then down-wrap from 0 to lim.
        bin_step(1, 0, 0, 0, 0, 1, 1, 5);
        for (int i = 1; i <= 6; i++) begin
            bin_step(1, 1, 0, 1, 1, 1, 1, 5);
            chk("mod_up", {24'd0, bi.q}, i % 6);
        end
        chk("mod_tc", {31'd0, bi.tc_pulse}, 1);
        bin_step(1, 1, 0, 1, 1, 0, 1, 5);
        chk("mod_down", {24'd0, bi.q}, 5);
        // Modulo with q above lim counts through the natural wrap.
        bin_step(1, 0, 8'hFE, 0, 0, 1, 1, 5);
        bin_step(1, 1, 0, 1, 1, 1, 1, 5);
        bin_step(1, 1, 0, 1, 1, 1, 1, 5);
        chk("mod_over", {24'd0, bi.q}, 0);

        // One-shot lim 3.
        bin_step(1, 0, 0, 0, 0, 1, 2, 3);
        for (int i = 1; i <= 3; i++) bin_step(1, 1, 0, 1, 1, 1, 2, 3);
        chk("os_q3", {24'd0, bi.q}, 3);
        bin_step(1, 1, 0, 1, 1, 1, 2, 3);
        chk("os_done", {31'd0, bi.done}, 1);
        chk("os_hold", {24'd0, bi.q}, 3);
        chk("os_tc", {31'd0, bi.tc_pulse}, 1);
        bin_step(1, 1, 0, 1, 1, 1, 2, 3);
        bin_step(1, 1, 0, 1, 1, 1, 2, 3);
        chk("os_inhibit", {24'd0, bi.q}, 3);
        bin_step(1, 0, 0, 0, 0, 1, 2, 3);
        chk("os_clear", {31'd0, bi.done}, 0);

        // Priority.
        bin_step(1, 0, 8'h33, 0, 0, 1, 0, 0);
        bin_step(0, 0, 8'h77, 1, 1, 1, 0, 0);
        chk("pri_sclr", {24'd0, bi.q}, 0);
        bin_step(1, 0, 8'h5A, 1, 1, 1, 0, 0);
        chk("pri_load", {24'd0, bi.q}, 32'h5A);
        bin_step(1, 0, 8'hFF, 0, 0, 1, 0, 0);
        bin_step(1, 1, 0, 1, 0, 1, 0, 0);
        chk("pri_hold", {24'd0, bi.q}, 32'hFF);
        chk("pri_rco", {31'd0, bi.rco}, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bin_step(($urandom_range(0, 19) != 0), ($urandom_range(0, 11) != 0),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 8),
                     ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                     $urandom_range(0, 1), $urandom_range(0, 3),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 8));
        end

        // Asynchronous reset between edges after a one-shot completes.
        bin_step(1, 0, 0, 0, 0, 1, 2, 2);
        for (int i = 0; i < 3; i++) bin_step(1, 1, 0, 1, 1, 1, 2, 2);
        chk("pre_rst_done", {31'd0, bi.done}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_q",    {24'd0, bi.q},        0);
        chk("arst_tc",   {31'd0, bi.tc_pulse}, 0);
        chk("arst_done", {31'd0, bi.done},     0);
        m_q = 0; m_done = 0; m_tc = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bin_step(1, 1, 0, 1, 1, 1, 0, 0);
        chk("arst_resume", {24'd0, bi.q}, 1);
        bi.ent = 1'b0; bi.enp = 1'b0;

        // BCD decade counting.
        bcd_step(0, 8'h98, 0, 1, 2'b00, 8'h00, 0, 8'h98, 0);
        bcd_step(1, 8'h00, 1, 1, 2'b00, 8'h00, 0, 8'h99, 0);
        bcd_step(1, 8'h00, 1, 1, 2'b00, 8'h00, 1, 8'h00, 1);
        bcd_step(1, 8'h00, 1, 0, 2'b00, 8'h00, 1, 8'h99, 1);
        bcd_step(0, 8'h0A, 0, 1, 2'b00, 8'h00, 0, 8'h0A, 0);
        bcd_step(1, 8'h00, 1, 1, 2'b00, 8'h00, 0, 8'h10, 0);
        bcd_step(0, 8'h0B, 0, 0, 2'b00, 8'h00, 0, 8'h0B, 0);
        bcd_step(1, 8'h00, 1, 0, 2'b00, 8'h00, 0, 8'h0A, 0);
        bcd_step(0, 8'h19, 0, 1, 2'b00, 8'h00, 0, 8'h19, 0);
        bcd_step(1, 8'h00, 1, 1, 2'b00, 8'h00, 0, 8'h20, 0);
        bcd_step(0, 8'h12, 0, 1, 2'b01, 8'h12, 0, 8'h12, 0);
        bcd_step(1, 8'h00, 1, 1, 2'b01, 8'h12, 1, 8'h00, 1);
        bcd_step(1, 8'h00, 1, 0, 2'b01, 8'h12, 1, 8'h12, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_counter.md
GEN_COUNTER -- requirements
Module: gen_counter

Interface
REQ-001 Parameter WIDTH, 8, counter width in bits; legal 4..32; SHALL be a multiple of 4 when BCD=1.
REQ-002 Parameter BCD, 0, 0 = binary count; 1 = each 4-bit nibble counts as a decade (0-9).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge except reset.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sclr_n  input  1  synchronous clear, active-low.
REQ-006 load_n  input  1  synchronous parallel load, active-low.
REQ-007 p  input  WIDTH  load data.
REQ-008 ent, enp  input  1 each  count enables; a count step SHALL require ent=1 and enp=1.
REQ-009 up  input  1  direction: 1 = up, 0 = down.
REQ-010 mode  input  2  00 = free-run, 01 = modulo, 10 = one-shot, 11 = treated as free-run.
REQ-011 lim  input  WIDTH  programmable limit for modulo and one-shot modes.
REQ-012 q  output  WIDTH  registered count.
REQ-013 rco  output  1  combinational: ent=1 and q equals the terminal value (TV) for the current direction.
REQ-014 tc_pulse  output  1  registered one-cycle event flag.
REQ-015 done  output  1  registered one-shot completion flag.

Function
REQ-016 TV SHALL be: down -> 0; up in free-run -> all-ones (binary) or all nibbles 9 (BCD); up in modulo/one-shot -> lim.
REQ-017 Priority SHALL be: rst_n > sclr_n > load_n > count step > hold.
REQ-018 sclr_n=0 at an edge SHALL set q=0, done=0, tc_pulse=0.
REQ-019 load_n=0 at an edge SHALL set q=p, done=0, tc_pulse=0; p is not range-checked.
REQ-020 Step with q != TV SHALL set q = q+1 (up) or q-1 (down); tc_pulse=0.
REQ-021 Free-run step at TV SHALL wrap: up -> 0, down -> all-ones/all-9; tc_pulse=1 next cycle.
REQ-022 Modulo step at TV SHALL wrap: up -> 0, down -> lim; tc_pulse=1 next cycle.
REQ-023 Modulo up with q > lim (binary compare) SHALL count up naturally through the free-run wrap; no forced correction.
REQ-024 One-shot step at TV with done=0 SHALL hold q, set done=1, set tc_pulse=1.
REQ-025 While done=1, all count steps SHALL be inhibited; q holds; tc_pulse=0; done clears only via rst_n, sclr_n or load_n.
REQ-026 BCD up: nibble 9 -> 0 with carry into next nibble; a nibble >9 SHALL be treated as 9 (-> 0, carry).
REQ-027 BCD down: nibble 0 -> 9 with borrow into next nibble; a nibble >9 SHALL decrement in binary with no borrow.
REQ-028 tc_pulse SHALL be 0 on every edge not described in REQ-021/022/024; it never stays high two cycles from one event.
REQ-029 Changing mode, up or lim mid-count SHALL take effect at the next edge; q is not modified by the change itself.
REQ-030 rco SHALL follow q, up, mode, lim and ent combinationally; it SHALL be independent of enp, load_n and done.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, force q=0, tc_pulse=0, done=0.
REQ-032 Deassertion of rst_n SHALL take effect at the first rising clk edge after rst_n=1; reset mid-count SHALL discard the count in progress.

Verification
REQ-033 WIDTH=8, BCD=0, mode=00, up=1: load 0xFE, count 2 -> q 0xFF then 0x00; rco=1 while q=0xFF; tc_pulse=1 for one cycle after wrap.
REQ-034 WIDTH=8, BCD=1, up=1: load 0x98, count 2 -> 0x99, 0x00; up=0 from 0x00 -> 0x99; load 0x0A, up=1 -> 0x10.
REQ-035 mode=01, lim=5: up from 0 -> 0,1,2,3,4,5,0; down from 0 -> 5; tc_pulse once per wrap.
REQ-036 mode=10, lim=3, up=1: from 0 -> 1,2,3, then done=1, q holds at 3, tc_pulse one cycle; further enables leave q=3; load_n=0, p=0 -> done=0.
REQ-037 Priority: sclr_n=0, load_n=0 and ent=enp=1 together -> q=0; load_n=0 with ent=enp=1 -> q=p; enp=0 -> hold with rco still valid.
REQ-038 Assert rst_n=0 mid-count between clock edges -> q=0, done=0, tc_pulse=0 immediately; after release, counting resumes from 0.
